alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
Multi-cycle control sequencer for the 24-bit processor datapath built around the ALU (A bus = AC, B bus = selected register, C bus = writeback).
- Fetches each instruction over a ready-handshaked memory port, decodes a 4-bit opcode and drives the ALU `oper` code, the B-bus select, register load enables and memory strobes.
- Keeps the architectural Z flag, which the conditional jump uses.
- Sits between the instruction/data memory port and the register/ALU datapath.

Parameters:
- WAIT_LIMIT, 255: consecutive `mem_ready`-low cycles tolerated per memory request before a bus error is raised; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  4  IR[23:20], valid from DECODE onward.
- z_flag  in  1  ALU `Z_flag`.
- mem_ready  in  1  memory completes the current request.
- alu_oper  out  4  ALU code: 0 idle, 1 ADD, 2 SUB, 3 LSHFT1, 6 RSHFT4, 7 PASSATOC, 8 PASSBTOC, 9 INCAC, 10 DECAC, 11 RESET.
- b_sel  out  3  B-bus source: 0 none, 1 R, 2 DR, 3 IR operand, 4 PC.
- ld_en  out  6  register loads, one-hot per cycle: [0]AC [1]R [2]DR [3]AR [4]IR [5]PC.
- pc_inc  out  1  PC += 1 this edge.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request (data = DR).
- mem_addr_sel  out  1  address source: 0 PC, 1 AR.
- z_reg  out  1  architectural Z flag.
- state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  out  1  in HALT state.
- bus_err  out  1  sticky memory timeout flag.

Behaviour:
- **Reset (async, reset_n low):**
  - state=FETCH, z_reg=0, bus_err=0, wait counter=0.
  - All strobes, alu_oper, b_sel, ld_en and pc_inc are 0 immediately, not at the next edge.
- **Output timing:** outputs are combinational from state, opcode and z_reg (Moore/Mealy-on-opcode); all registers update on the rising edge of clk.
- **FETCH:**
  - mem_rd=1, mem_addr_sel=0, held stable until mem_ready.
  - In the mem_ready cycle: ld_en[4]=1, pc_inc=1, next state DECODE.
- **DECODE:** all outputs idle.
  - opcode 0 → FETCH; opcode F → HALT; opcode 1 → MEM; all others → EXEC.
- **EXEC** (1 cycle, then FETCH unless noted):
  - 2 STAC: oper 7, ld DR, next MEM.
  - 3 LDAR: oper 8, b_sel 3, ld AR.
  - 4 MVACR: oper 7, ld R.
  - 5 MVRAC: oper 8, b_sel 1, ld AC.
  - 6 ADD: oper 1, b_sel 1, ld AC.
  - 7 SUB: oper 2, b_sel 1, ld AC; z_reg ← z_flag at this edge.
  - 8 INAC: oper 9, ld AC.
  - 9 DEAC: oper 10, ld AC.
  - A LSHFT1: oper 3, ld AC.
  - B RSHFT4: oper 6, ld AC.
  - C CLAC: oper 11, ld AC.
  - D JUMP: oper 8, b_sel 3, ld PC.
  - E JMPZ: as JUMP if z_reg=1, otherwise all outputs idle.
- **MEM:** mem_addr_sel=1.
  - LDAC: mem_rd=1; in the ready cycle ld DR, next WB.
  - STAC: mem_wr=1; in the ready cycle next FETCH.
- **WB (LDAC only):** oper 8, b_sel 2, ld AC, next FETCH.
- **z_reg:** changes only on SUB; all other instructions leave it untouched.
- **Latencies with zero-wait memory:**
  - NOP: 2 cycles.
  - ALU and jump instructions: 3 cycles.
  - LDAC, STAC: 4 cycles.
  - Each wait cycle adds 1.
- **Timeout:**
  - The counter increments on each FETCH/MEM cycle with mem_ready=0 and clears on ready or state exit.
  - When the counter reaches WAIT_LIMIT (ready still low at that edge), next state HALT and bus_err=1.
  - A mem_ready arriving in the limit cycle wins; no error is raised.
- **HALT:** sticky. halted=1, all strobes 0, mem_ready ignored; only reset_n exits.
- mem_ready is ignored in DECODE, EXEC, WB and HALT.
- **Reset mid-request:** mem_rd/mem_wr drop asynchronously. After release, the unit fetches from the current PC (the PC register is reset by the datapath).

Test Plan:
1. Reset, mem_ready=1, opcode 6 (ADD) → state 0,1,2,0; alu_oper=1, b_sel=1, ld_en=000001 only in EXEC; one pc_inc per fetch; 3 cycles total.
2. SUB with z_flag=1, then JMPZ → z_reg=1 after the SUB EXEC edge; JMPZ EXEC drives oper 8, b_sel 3, ld_en=100000. Repeat with z_flag=0 → JMPZ EXEC all zero, ld_en=0.
3. LDAC, mem_ready low 3 cycles in MEM → mem_rd=1 and mem_addr_sel=1 held 4 cycles; ld_en=000100 only in the ready cycle; WB drives oper 8, b_sel 2, ld_en=000001.
4. STAC → EXEC oper 7, ld DR; MEM mem_wr=1 until ready; mem_rd never asserted.
5. WAIT_LIMIT=4, mem_ready stuck 0 in FETCH → after 4 low cycles state=5, bus_err=1, halted=1, mem_rd=0. Variant: ready in the 4th cycle → no error.
6. Opcode F → halted=1, no further mem_rd. reset_n low during the MEM wait of an LDAC → mem_rd=0 in the same cycle; after release state=0, z_reg=0, bus_err=0.

Source files
------------

// File: rtl/alu_control_unit_if.sv
// Memory port between the control sequencer and the instruction/data memory.
//   mem_rd       : read request
//   mem_wr       : write request (write data comes from DR)
//   mem_addr_sel : address source, 0 = PC, 1 = AR
//   mem_ready    : memory completes the current request this cycle
interface alu_control_unit_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/alu_control_unit.sv
// Multi-cycle control sequencer for the 24-bit ALU datapath.
// Fetches over a ready-handshaked memory port, decodes a 4-bit opcode and
// drives ALU oper, B-bus select, register loads and memory strobes.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   opcode, z_flag        : IR[23:20] and ALU zero flag
//   mem (master)          : mem_rd/mem_wr/mem_addr_sel out, mem_ready in
//   alu_oper, b_sel       : ALU operation and B-bus source
//   ld_en, pc_inc         : one-hot register loads, PC increment
//   z_reg, bus_err        : architectural Z flag, sticky memory timeout
//   state, halted         : debug state code, HALT indicator
module alu_control_unit #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         opcode,
  input  logic               z_flag,
  alu_control_unit_if.master mem,
  output logic [3:0]         alu_oper,
  output logic [2:0]         b_sel,
  output logic [5:0]         ld_en,
  output logic               pc_inc,
  output logic               z_reg,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_IDLE = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LSH1 = 4'd3,  OP_RSH4 = 4'd6,  OP_PASA = 4'd7;
  localparam logic [3:0] OP_PASB = 4'd8,  OP_INC  = 4'd9,  OP_DEC  = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;

  localparam logic [2:0] B_NONE = 3'd0, B_R = 3'd1, B_DR = 3'd2, B_IR = 3'd3;

  localparam logic [5:0] LD_AC = 6'b000001, LD_R  = 6'b000010, LD_DR = 6'b000100;
  localparam logic [5:0] LD_AR = 6'b001000, LD_IR = 6'b010000, LD_PC = 6'b100000;

  localparam logic [3:0] I_NOP  = 4'h0, I_LDAC = 4'h1, I_STAC = 4'h2, I_LDAR = 4'h3;
  localparam logic [3:0] I_MVAC = 4'h4, I_MVRA = 4'h5, I_ADD  = 4'h6, I_SUB  = 4'h7;
  localparam logic [3:0] I_INAC = 4'h8, I_DEAC = 4'h9, I_LSH1 = 4'hA, I_RSH4 = 4'hB;
  localparam logic [3:0] I_CLAC = 4'hC, I_JUMP = 4'hD, I_JMPZ = 4'hE, I_HALT = 4'hF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0] oper_c;
  logic [2:0] bsel_c;
  logic [5:0] ld_c;
  logic       pcinc_c, rd_c, wr_c, asel_c;
  logic       timeout_c;

  // Last tolerated low-ready cycle: a low mem_ready here trips the timeout
  assign timeout_c = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  // State and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      z_q       <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state and control decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    z_d       = z_q;
    bus_err_d = bus_err_q;
    oper_c    = OP_IDLE;
    bsel_c    = B_NONE;
    ld_c      = '0;
    pcinc_c   = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    asel_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        rd_c = 1'b1;
        if (mem.mem_ready) begin
          ld_c    = LD_IR;
          pcinc_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        case (opcode)
          I_NOP:   state_d = S_FETCH;
          I_HALT:  state_d = S_HALT;
          I_LDAC:  state_d = S_MEM;
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          I_STAC: begin oper_c = OP_PASA; ld_c = LD_DR; state_d = S_MEM; end
          I_LDAR: begin oper_c = OP_PASB; bsel_c = B_IR; ld_c = LD_AR; end
          I_MVAC: begin oper_c = OP_PASA; ld_c = LD_R; end
          I_MVRA: begin oper_c = OP_PASB; bsel_c = B_R; ld_c = LD_AC; end
          I_ADD:  begin oper_c = OP_ADD;  bsel_c = B_R; ld_c = LD_AC; end
          I_SUB:  begin oper_c = OP_SUB;  bsel_c = B_R; ld_c = LD_AC; z_d = z_flag; end
          I_INAC: begin oper_c = OP_INC;  ld_c = LD_AC; end
          I_DEAC: begin oper_c = OP_DEC;  ld_c = LD_AC; end
          I_LSH1: begin oper_c = OP_LSH1; ld_c = LD_AC; end
          I_RSH4: begin oper_c = OP_RSH4; ld_c = LD_AC; end
          I_CLAC: begin oper_c = OP_CLR;  ld_c = LD_AC; end
          I_JUMP: begin oper_c = OP_PASB; bsel_c = B_IR; ld_c = LD_PC; end
          I_JMPZ: begin
            if (z_q) begin
              oper_c = OP_PASB;
              bsel_c = B_IR;
              ld_c   = LD_PC;
            end
          end
          default: ;
        endcase
      end

      // Only LDAC and STAC reach MEM; anything other than LDAC is the store
      S_MEM: begin
        asel_c = 1'b1;
        if (opcode == I_LDAC) rd_c = 1'b1;
        else                  wr_c = 1'b1;
        if (mem.mem_ready) begin
          if (opcode == I_LDAC) begin
            ld_c    = LD_DR;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (timeout_c) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        oper_c  = OP_PASB;
        bsel_c  = B_DR;
        ld_c    = LD_AC;
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, independent of the clock
  assign mem.mem_rd       = reset_n & rd_c;
  assign mem.mem_wr       = reset_n & wr_c;
  assign mem.mem_addr_sel = reset_n & asel_c;
  assign alu_oper         = reset_n ? oper_c : 4'd0;
  assign b_sel            = reset_n ? bsel_c : 3'd0;
  assign ld_en            = reset_n ? ld_c   : 6'd0;
  assign pc_inc           = reset_n & pcinc_c;

  assign state   = 3'(state_q);
  assign halted  = (state_q == S_HALT);
  assign z_reg   = z_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: a per-instruction cycle model
// builds the expected output trace, which is played against the DUT.
module tb_alu_control_unit;

  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] oper;
    logic [2:0] bsel;
    logic [5:0] ld;
    logic       pcinc;
    logic       rd;
    logic       wr;
    logic       asel;
    logic       z;
    logic       halted;
    logic       berr;
  } obs_t;

  typedef struct packed {
    logic       ready;
    logic [3:0] opc;
    logic       zf;
  } drv_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       z_flag = 1'b0;
  logic [3:0] alu_oper;
  logic [2:0] b_sel;
  logic [5:0] ld_en;
  logic       pc_inc;
  logic       z_reg;
  logic [2:0] state;
  logic       halted;
  logic       bus_err;

  alu_control_unit_if mem_if ();

  alu_control_unit #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .opcode   (opcode),
    .z_flag   (z_flag),
    .mem      (mem_if),
    .alu_oper (alu_oper),
    .b_sel    (b_sel),
    .ld_en    (ld_en),
    .pc_inc   (pc_inc),
    .z_reg    (z_reg),
    .state    (state),
    .halted   (halted),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic z_m      = 1'b0;
  logic berr_m   = 1'b0;

  drv_t drv_q[$];
  obs_t exp_q[$];
  obs_t cmp_q[$];
  obs_t act_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.oper = alu_oper; o.bsel = b_sel; o.ld = ld_en;
    o.pcinc = pc_inc; o.rd = mem_if.mem_rd; o.wr = mem_if.mem_wr;
    o.asel = mem_if.mem_addr_sel; o.z = z_reg; o.halted = halted; o.berr = bus_err;
    return o;
  endfunction

  // Idle outputs for a given state code, carrying the model's flags
  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st; o.z = z_m; o.berr = berr_m; o.halted = (st == 3'd5);
    return o;
  endfunction

  function automatic drv_t rnd_drv(input logic [3:0] opc);
    drv_t d;
    d.ready = 1'($urandom); d.opc = opc; d.zf = 1'($urandom);
    return d;
  endfunction

  // EXEC micro-op table: {oper, b_sel, ld_en}
  function automatic logic [12:0] exec_uop(input logic [3:0] op, input logic z);
    case (op)
      4'h2: return {4'd7,  3'd0, 6'b000100};
      4'h3: return {4'd8,  3'd3, 6'b001000};
      4'h4: return {4'd7,  3'd0, 6'b000010};
      4'h5: return {4'd8,  3'd1, 6'b000001};
      4'h6: return {4'd1,  3'd1, 6'b000001};
      4'h7: return {4'd2,  3'd1, 6'b000001};
      4'h8: return {4'd9,  3'd0, 6'b000001};
      4'h9: return {4'd10, 3'd0, 6'b000001};
      4'hA: return {4'd3,  3'd0, 6'b000001};
      4'hB: return {4'd6,  3'd0, 6'b000001};
      4'hC: return {4'd11, 3'd0, 6'b000001};
      4'hD: return {4'd8,  3'd3, 6'b100000};
      4'hE: return z ? {4'd8, 3'd3, 6'b100000} : 13'd0;
      default: return 13'd0;
    endcase
  endfunction

  task automatic push(input drv_t d, input obs_t o);
    drv_q.push_back(d);
    exp_q.push_back(o);
  endtask

  task automatic build_halt(input int n);
    for (int i = 0; i < n; i++) push(rnd_drv(4'($urandom)), base(3'd5));
  endtask

  // Expected cycle trace of one instruction: wf / wm wait cycles in FETCH / MEM
  task automatic build_instr(input logic [3:0] op, input logic zf, input int wf, input int wm);
    obs_t o;
    drv_t d;
    for (int i = 0; i <= wf; i++) begin
      o = base(3'd0); o.rd = 1'b1;
      d.ready = (i == wf); d.opc = 4'($urandom); d.zf = 1'($urandom);
      if (i == wf) begin o.ld = 6'b010000; o.pcinc = 1'b1; end
      push(d, o);
    end
    push(rnd_drv(op), base(3'd1));
    if (op == 4'h0) return;
    if (op == 4'hF) begin build_halt(4); return; end
    if (op == 4'h1) begin
      for (int i = 0; i <= wm; i++) begin
        o = base(3'd3); o.rd = 1'b1; o.asel = 1'b1;
        d = rnd_drv(op); d.ready = (i == wm);
        if (i == wm) o.ld = 6'b000100;
        push(d, o);
      end
      o = base(3'd4); o.oper = 4'd8; o.bsel = 3'd2; o.ld = 6'b000001;
      push(rnd_drv(op), o);
      return;
    end
    o = base(3'd2);
    {o.oper, o.bsel, o.ld} = exec_uop(op, z_m);
    d = rnd_drv(op);
    if (op == 4'h7) d.zf = zf;
    push(d, o);
    if (op == 4'h7) z_m = zf;
    if (op == 4'h2) begin
      for (int i = 0; i <= wm; i++) begin
        o = base(3'd3); o.wr = 1'b1; o.asel = 1'b1;
        d = rnd_drv(op); d.ready = (i == wm);
        push(d, o);
      end
    end
  endtask

  // Plays up to n queued cycles; starts and ends 1 time unit after a rising edge
  task automatic play(input int n);
    drv_t d;
    int   k;
    k = 0;
    cmp_q.delete();
    act_q.delete();
    while (exp_q.size() > 0 && k < n) begin
      d = drv_q.pop_front();
      cmp_q.push_back(exp_q.pop_front());
      mem_if.mem_ready = d.ready;
      opcode = d.opc;
      z_flag = d.zf;
      #3;
      act_q.push_back(sample());
      @(posedge clk);
      #1;
      k++;
    end
    drv_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    mem_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    z_m = 1'b0;
    berr_m = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_ready = 1'($urandom);
      opcode = 4'($urandom);
      z_flag = 1'($urandom);
      #2;
      o = sample();
      n_checks++;
      if (o !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset cyc%0d actual=%h required=%h", i, o, obs_t'(0));
      end
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    z_m = 1'b0;
    berr_m = 1'b0;
  endtask

  task automatic test_add();
    build_instr(4'h6, 1'b0, 0, 0);
    build_instr(4'h6, 1'b0, 2, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL add cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_sub_jmpz();
    build_instr(4'h7, 1'b1, 0, 0);
    build_instr(4'hE, 1'b0, 0, 0);
    build_instr(4'h7, 1'b0, 1, 0);
    build_instr(4'hE, 1'b0, 0, 0);
    build_instr(4'hD, 1'b0, 0, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL sub_jmpz cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_ldac_stac();
    build_instr(4'h1, 1'b0, 0, 3);
    build_instr(4'h2, 1'b0, 0, 2);
    build_instr(4'h1, 1'b0, 1, 0);
    build_instr(4'h2, 1'b0, 0, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL ldac_stac cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      build_instr(4'($urandom_range(14, 0)), 1'($urandom),
                  int'($urandom_range(LIMIT - 1, 0)), int'($urandom_range(LIMIT - 1, 0)));
    play(100000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drv_t d;
    // ready in the last tolerated cycle: no error
    apply_reset();
    build_instr(4'h6, 1'b0, LIMIT - 1, 0);
    build_instr(4'h1, 1'b0, 0, LIMIT - 1);
    // ready never arrives: HALT with bus_err after LIMIT low cycles
    for (int i = 0; i < LIMIT; i++) begin
      o = base(3'd0); o.rd = 1'b1;
      d = rnd_drv(4'($urandom)); d.ready = 1'b0;
      push(d, o);
    end
    berr_m = 1'b1;
    build_halt(4);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL timeout cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset();
    build_instr(4'h8, 1'b0, 0, 0);
    build_instr(4'hF, 1'b0, 0, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL halt cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    apply_reset();
    build_instr(4'h7, 1'b1, 0, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
    // stop inside the LDAC memory wait, then pull reset mid-cycle
    build_instr(4'h1, 1'b0, 0, 3);
    play(4);
    mem_if.mem_ready = 1'b0;
    opcode = 4'h1;
    #1;
    o = sample();
    n_checks++;
    if (o.rd !== 1'b1 || o.st !== 3'd3 || o.z !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_wait actual=%h rd/st/z required=1/3/1", o);
    end
    reset_n = 1'b0;
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_async actual=%h required=%h", o, obs_t'(0));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    z_m = 1'b0;
    berr_m = 1'b0;
    build_instr(4'h0, 1'b0, 1, 0);
    build_instr(4'hE, 1'b0, 0, 0);
    play(1000);
    for (int i = 0; i < cmp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== cmp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid_post cyc%0d actual=%h required=%h", i, act_q[i], cmp_q[i]);
      end
    end
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_jmpz();
    test_ldac_stac();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
